candy_inst_enc: RTL and testbench

//  Instruction encoder for the 24-bit candy ISA; the inverse of the ID-stage field decode.

---
 rtl/candy_inst_enc.sv | 177 +++++++++++++++++
 tb/tb_candy_inst_enc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/candy_inst_enc.sv
// Candy ISA instruction encoder: packs field bundles into 24-bit words, tags each with a
// sequential imem address and queues them in a small FIFO. Optional range check: CANDY_ENC_CHECK_EN.
module candy_inst_enc #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [5:0]        in_op,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [3:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  input  logic              err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_S = 2'b10;
  localparam logic [1:0] FMT_U = 2'b11;

  typedef struct packed {
    logic [23:0]       inst;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            entry_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0] addr_cur;
  logic [23:0]       enc_word;
  logic              accept;
  logic              pop;
  logic              push;

  // Field packing; bits not owned by the selected format stay zero.
  always_comb begin
    enc_word        = '0;
    enc_word[23:22] = in_type;
    case (in_type)
      FMT_R: begin
        enc_word[21:16] = in_op;
        enc_word[15:12] = in_rs1;
        enc_word[11:8]  = in_rs2;
        enc_word[7:4]   = in_rd;
      end
      FMT_I: begin
        enc_word[21:18] = in_op[3:0];
        enc_word[17:14] = in_rs1;
        enc_word[13:10] = in_rd;
        enc_word[9:0]   = in_imm[9:0];
      end
      FMT_S: begin
        enc_word[21:18] = in_op[3:0];
        enc_word[17:14] = in_rs1;
        enc_word[13:10] = in_rs2;
        enc_word[9:0]   = in_imm[9:0];
      end
      default: begin
        enc_word[21:20] = in_op[1:0];
        enc_word[19:16] = in_rd;
        enc_word[15:0]  = in_imm;
      end
    endcase
  end

  // in_ready depends only on registered occupancy, so a pop never frees a slot the same cycle.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign addr_cur  = addr_load ? addr_base : addr_cnt_q;

`ifdef CANDY_ENC_CHECK_EN
  logic viol;
  logic err_q, err_d;

  always_comb begin
    viol = 1'b0;
    case (in_type)
      FMT_I, FMT_S: viol = (in_op[5:4] != 2'b00) || (in_imm[15:10] != 6'd0);
      FMT_U:        viol = (in_op[5:2] != 4'd0);
      default:      viol = 1'b0;
    endcase
  end

  assign push = accept & ~viol;

  // A violation in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (accept && viol) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign push           = accept;
  assign err            = 1'b0;
`endif

  always_comb begin
    entry_d    = '{inst: enc_word, addr: addr_cur};
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    addr_cnt_d = addr_cnt_q;
    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      addr_cnt_d = addr_cur + ADDR_W'(1);
    end else if (addr_load) begin
      addr_cnt_d = addr_base;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_cnt_q <= addr_cnt_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

  assign out_inst = mem_q[rd_ptr_q].inst;
  assign out_addr = mem_q[rd_ptr_q].addr;

endmodule

// File: tb/tb_candy_inst_enc.sv
// Bench for candy_inst_enc: vector table, directed corner sequences and random traffic
// against a queue-based reference model.
module tb_candy_inst_enc;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_base;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_type;
  logic [5:0]        in_op;
  logic [3:0]        in_rs1, in_rs2, in_rd;
  logic [15:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [23:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic              err_clr;

  always #5 clk = ~clk;

  candy_inst_enc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .addr_load(addr_load), .addr_base(addr_base),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .err(err), .err_clr(err_clr)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [5:0]  op;
    logic [3:0]  rs1, rs2, rd;
    logic [15:0] imm;
    logic [23:0] exp_inst;
  } vec_t;

  typedef struct {
    logic [23:0]       inst;
    logic [ADDR_W-1:0] addr;
  } ent_t;

  vec_t tbl[7];
  ent_t q[$];
  int   cnt_m;
  bit   err_m;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Word layout from the format rules, built with shifts and field weights.
  function automatic int ref_enc(int typ, int op, int rs1, int rs2, int rd, int imm);
    int w;
    w = typ * (1 << 22);
    case (typ)
      0: w += (op % 64) * (1 << 16) + rs1 * (1 << 12) + rs2 * (1 << 8) + rd * 16;
      1: w += (op % 16) * (1 << 18) + rs1 * (1 << 14) + rd * (1 << 10) + imm % 1024;
      2: w += (op % 16) * (1 << 18) + rs1 * (1 << 14) + rs2 * (1 << 10) + imm % 1024;
      default: w += (op % 4) * (1 << 20) + rd * (1 << 16) + imm % 65536;
    endcase
    return w;
  endfunction

  function automatic bit ref_viol(int typ, int op, int imm);
`ifdef CANDY_ENC_CHECK_EN
    if (typ == 1 || typ == 2) return (op >= 16) || (imm >= 1024);
    if (typ == 3) return op >= 4;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model with the current inputs, clock once, compare all outputs.
  task automatic step();
    bit acc, pop, v;
    int base;
    ent_t e;
    if (rst) begin
      q.delete();
      cnt_m = 0;
      err_m = 1'b0;
    end else begin
      acc  = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() > 0);
      base = addr_load ? int'(addr_base) : cnt_m;
      v    = acc && ref_viol(int'(in_type), int'(in_op), int'(in_imm));
      if (pop) void'(q.pop_front());
      if (acc && !v) begin
        e.inst = 24'(ref_enc(int'(in_type), int'(in_op), int'(in_rs1), int'(in_rs2),
                             int'(in_rd), int'(in_imm)));
        e.addr = ADDR_W'(base);
        q.push_back(e);
        cnt_m = (base + 1) % (1 << ADDR_W);
      end else if (addr_load) begin
        cnt_m = base;
      end
      if (v) err_m = 1'b1;
      else if (err_clr) err_m = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("err", 32'(err), 32'(err_m));
    if (q.size() > 0) begin
      chk("out_inst", 32'(out_inst), 32'(q[0].inst));
      chk("out_addr", 32'(out_addr), 32'(q[0].addr));
    end
  endtask

  task automatic set_fields(input logic [1:0] t, input logic [5:0] op, input logic [3:0] r1,
                            input logic [3:0] r2, input logic [3:0] rd, input logic [15:0] imm);
    in_type = t; in_op = op; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_imm = imm;
  endtask

  initial begin
    tbl[0] = '{2'b00, 6'h2A, 4'h3, 4'h5, 4'h7, 16'h0000, 24'h2A3570};
    tbl[1] = '{2'b01, 6'h09, 4'h2, 4'h0, 4'h4, 16'h0155, 24'h649155};
    tbl[2] = '{2'b11, 6'h02, 4'h0, 4'h0, 4'hF, 16'hBEEF, 24'hEFBEEF};
    tbl[3] = '{2'b10, 6'h03, 4'h1, 4'hA, 4'h0, 16'h03FF, 24'h8C6BFF};
    tbl[4] = '{2'b00, 6'h3F, 4'hF, 4'hF, 4'hF, 16'hFFFF, 24'h3FFFF0};
    tbl[5] = '{2'b01, 6'h00, 4'h0, 4'hF, 4'h0, 16'h0000, 24'h400000};
    tbl[6] = '{2'b01, 6'h0F, 4'hF, 4'h0, 4'hF, 16'h03FF, 24'h7FFFFF};

    rst = 1'b1; addr_load = 1'b0; addr_base = '0; in_valid = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    set_fields(2'b00, 6'h0, 4'h0, 4'h0, 4'h0, 16'h0);
    cnt_m = 0; err_m = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_out_inst", 32'(out_inst), 32'h0);
    chk("rst_out_addr", 32'(out_addr), 32'h0);
    rst = 1'b0;
    step();

    // Vector table, streamed back-to-back with the consumer always ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_fields(tbl[i].typ, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm);
      step();
      chk("tbl_inst", 32'(out_inst), 32'(tbl[i].exp_inst));
      chk("tbl_addr", 32'(out_addr), 32'(i));
      $display("vec %0d: type=%0d inst=%06h addr=%0h", i, tbl[i].typ, out_inst, out_addr);
    end
    in_valid = 1'b0;
    step();

    // Full FIFO: 5 offered, 4 taken, then one pop frees a slot the following cycle
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    set_fields(2'b00, 6'h11, 4'h1, 4'h2, 4'h3, 16'h0);
    for (int i = 0; i < 5; i++) step();
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_head_addr", 32'(out_addr), 32'h0);
    out_ready = 1'b1;
    step();
    chk("after_pop_in_ready", 32'(in_ready), 32'h1);
    chk("after_pop_head", 32'(out_addr), 32'h1);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("full_5th_addr", 32'(out_addr), 32'h4);
    step();

    // Address load together with the first accept, then wrap
    in_valid = 1'b1; addr_load = 1'b1; addr_base = 4'hE;
    step();
    chk("load_addr0", 32'(out_addr), 32'hE);
    addr_load = 1'b0;
    step();
    chk("load_addr1", 32'(out_addr), 32'hF);
    step();
    chk("wrap_addr2", 32'(out_addr), 32'h0);
    in_valid = 1'b0;
    step();

    // Reset with three words queued
    out_ready = 1'b0; in_valid = 1'b1;
    step(); step(); step();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    in_valid = 1'b1;
    step();
    chk("midrst_addr", 32'(out_addr), 32'h0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();

`ifdef CANDY_ENC_CHECK_EN
    // Out-of-range immediate is handshaken but dropped and flags err
    in_valid = 1'b1;
    set_fields(2'b01, 6'h01, 4'h1, 4'h0, 4'h2, 16'h0400);
    step();
    chk("chk_err_set", 32'(err), 32'h1);
    chk("chk_dropped", 32'(out_valid), 32'h0);
    set_fields(2'b01, 6'h01, 4'h1, 4'h0, 4'h2, 16'h03FF);
    step();
    chk("chk_next_addr", 32'(out_addr), 32'h1);
    in_valid = 1'b0; err_clr = 1'b1;
    step();
    chk("chk_err_clr", 32'(err), 32'h0);
    err_clr = 1'b0;
`endif

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 1) == 1);
      addr_load = ($urandom_range(0, 19) == 0);
      addr_base = ADDR_W'($urandom);
      err_clr   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      set_fields(2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 1023)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
